fifo_wr_arbiter: RTL and testbench

Write-side scheduler for the asynchronous FIFO, in the FIFO write-clock domain. Two requesters (ALU result path and register-file read path) share the single FIFO write port. Each requester submits an atomic 1- or 2-word frame; the arbiter grants round-robin, serialises the frame into the FIFO under FULL backpressure, and acknowledges completion.

---
 rtl/fifo_wr_arbiter_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_if.sv | 38 +++
 rtl/fifo_wr_arbiter_rr.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
// Consumers: fifo_wr_arbiter, rr_arbiter2.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2,
      ACK   = 2'd3
   } arb_state_t;

   localparam logic REQ_IDX0 = 1'b0;
   localparam logic REQ_IDX1 = 1'b1;

   localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester, FIFO write-port and status signals of the write arbiter.
// drop exists only when FIFO_ARB_TIMEOUT_EN is defined.
interface fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH = 8
);
   logic                    req0;
   logic                    req1;
   logic [2*DATA_WIDTH-1:0] data0;
   logic [2*DATA_WIDTH-1:0] data1;
   logic                    len0;
   logic                    len1;
   logic                    ack0;
   logic                    ack1;
   logic                    fifo_full;
   logic                    fifo_w_inc;
   logic [DATA_WIDTH-1:0]   fifo_wr_data;
   logic                    busy;
`ifdef FIFO_ARB_TIMEOUT_EN
   logic                    drop;
`endif

   modport master (
      input  req0, req1, data0, data1, len0, len1, fifo_full,
      output ack0, ack1, fifo_w_inc, fifo_wr_data, busy
`ifdef FIFO_ARB_TIMEOUT_EN
      , output drop
`endif
   );

   modport slave (
      output req0, req1, data0, data1, len0, len1, fifo_full,
      input  ack0, ack1, fifo_w_inc, fifo_wr_data, busy
`ifdef FIFO_ARB_TIMEOUT_EN
      , input drop
`endif
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr.sv
// Two-way round-robin grant; on a tie the requester not granted last wins.
// last_grant resets to 1 so requester 0 takes the first tie.
module rr_arbiter2
   import fifo_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic update,
   output logic grant
);

   logic last_grant;

   always_comb begin
      grant = REQ_IDX0;
      if (req0 && req1) begin
         grant = ~last_grant;
      end else if (req1) begin
         grant = REQ_IDX1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= REQ_IDX1;
      end else if (update) begin
         last_grant <= grant;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Serialises atomic 1/2-word frames from two requesters into one FIFO write port.
// FULL stalls in place; FIFO_ARB_TIMEOUT_EN adds a WR_LO stall timeout with drop.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8
`ifdef FIFO_ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
   input  logic               clk,
   input  logic               rst,
   fifo_wr_arbiter_if.master  bus
);

   arb_state_t              state_q;
   arb_state_t              state_d;
   logic [2*DATA_WIDTH-1:0] data_q;
   logic                    len_q;
   logic                    idx_q;
   logic                    grant;
   logic                    grant_en;

   rr_arbiter2 u_rr (
      .clk    (clk),
      .rst    (rst),
      .req0   (bus.req0),
      .req1   (bus.req1),
      .update (grant_en),
      .grant  (grant)
   );

`ifdef FIFO_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] stall_q;
   logic             drop_q;
   logic             abort;
`endif

   always_comb begin
      state_d  = state_q;
      grant_en = 1'b0;
`ifdef FIFO_ARB_TIMEOUT_EN
      abort    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               grant_en = 1'b1;
               state_d  = WR_LO;
            end
         end
         WR_LO: begin
            if (!bus.fifo_full) begin
               state_d = len_q ? WR_HI : ACK;
            end
`ifdef FIFO_ARB_TIMEOUT_EN
            // This full cycle is the TIMEOUT_CYCLES-th: abandon before any word goes out.
            else if (stall_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               abort   = 1'b1;
               state_d = ACK;
            end
`endif
         end
         WR_HI: begin
            if (!bus.fifo_full) begin
               state_d = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         len_q   <= 1'b0;
         idx_q   <= REQ_IDX0;
      end else begin
         state_q <= state_d;
         if (grant_en) begin
            data_q <= (grant == REQ_IDX1) ? bus.data1 : bus.data0;
            len_q  <= (grant == REQ_IDX1) ? bus.len1  : bus.len0;
            idx_q  <= grant;
         end
      end
   end

`ifdef FIFO_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         if (grant_en) begin
            stall_q <= '0;
            drop_q  <= 1'b0;
         end else if (state_q == WR_LO && bus.fifo_full) begin
            stall_q <= stall_q + 1'b1;
         end
         if (abort) begin
            drop_q <= 1'b1;
         end
      end
   end

   assign bus.drop = (state_q == ACK) && drop_q;
`endif

   assign bus.fifo_w_inc = ((state_q == WR_LO) || (state_q == WR_HI)) && !bus.fifo_full;
   assign bus.busy       = (state_q != IDLE);
   assign bus.ack0       = (state_q == ACK) && (idx_q == REQ_IDX0);
   assign bus.ack1       = (state_q == ACK) && (idx_q == REQ_IDX1);

   always_comb begin
      bus.fifo_wr_data = '0;
      if (state_q == WR_LO) begin
         bus.fifo_wr_data = data_q[DATA_WIDTH-1:0];
      end else if (state_q == WR_HI) begin
         bus.fifo_wr_data = data_q[2*DATA_WIDTH-1:DATA_WIDTH];
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: frame-queue reference model checked every cycle plus directed scenarios.
// The timeout scenario is built only when FIFO_ARB_TIMEOUT_EN is defined.
module tb_fifo_wr_arbiter;

   localparam int DW = 8;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fifo_wr_arbiter_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_ARB_TIMEOUT_EN
   fifo_wr_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
   fifo_wr_arbiter #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: the words of the granted frame still to be written; empty queue while active = ack cycle.
   bit            m_active = 1'b0;
   logic [DW-1:0] m_pend[$];
   int            m_owner  = 0;
   int            m_last   = 1;
   int            m_stall  = 0;
   bit            m_first  = 1'b0;
   bit            m_drop   = 1'b0;

   int            wr_cyc[$];
   logic [DW-1:0] wr_val[$];
   int            ack_cyc[$];
   int            ack_idx[$];
   int            drop_cyc[$];
   int            wb, ab, db, t0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] wv(input int i);
      return (wb + i < wr_val.size()) ? wr_val[wb + i] : 'x;
   endfunction
   function automatic int wc(input int i);
      return (wb + i < wr_cyc.size()) ? wr_cyc[wb + i] : -1;
   endfunction
   function automatic int ac(input int i);
      return (ab + i < ack_cyc.size()) ? ack_cyc[ab + i] : -1;
   endfunction
   function automatic int ai(input int i);
      return (ab + i < ack_idx.size()) ? ack_idx[ab + i] : -1;
   endfunction

   task automatic monitor_step();
      logic [2*DW-1:0] d;
      logic            l;
      bit              hold;
      int              w;
      if (rst) begin
         chk("rst_busy", bus.busy, 0);
         chk("rst_winc", bus.fifo_w_inc, 0);
         chk("rst_wdat", bus.fifo_wr_data, 0);
         chk("rst_ack0", bus.ack0, 0);
         chk("rst_ack1", bus.ack1, 0);
`ifdef FIFO_ARB_TIMEOUT_EN
         chk("rst_drop", bus.drop, 0);
`endif
         m_active = 1'b0;
         m_pend.delete();
         m_last = 1;
         m_drop = 1'b0;
      end else begin
         hold = m_active && (m_pend.size() > 0);
         chk("busy", bus.busy, m_active);
         chk("winc", bus.fifo_w_inc, hold && !bus.fifo_full);
         chk("wdat", bus.fifo_wr_data, hold ? m_pend[0] : '0);
         chk("ack0", bus.ack0, m_active && m_pend.size() == 0 && m_owner == 0);
         chk("ack1", bus.ack1, m_active && m_pend.size() == 0 && m_owner == 1);
`ifdef FIFO_ARB_TIMEOUT_EN
         chk("drop", bus.drop, m_active && m_pend.size() == 0 && m_drop);
`endif
         if (!m_active) begin
            if (bus.req0 || bus.req1) begin
               w = (bus.req0 && bus.req1) ? 1 - m_last : (bus.req1 ? 1 : 0);
               m_last = w;
               m_owner = w;
               d = (w == 1) ? bus.data1 : bus.data0;
               l = (w == 1) ? bus.len1 : bus.len0;
               m_pend.push_back(d[DW-1:0]);
               if (l) m_pend.push_back(d[2*DW-1:DW]);
               m_active = 1'b1;
               m_first  = 1'b1;
               m_stall  = 0;
               m_drop   = 1'b0;
            end
         end else if (m_pend.size() > 0) begin
            if (!bus.fifo_full) begin
               void'(m_pend.pop_front());
               m_first = 1'b0;
            end
`ifdef FIFO_ARB_TIMEOUT_EN
            else if (m_first) begin
               m_stall++;
               if (m_stall == TO) begin
                  m_pend.delete();
                  m_drop = 1'b1;
               end
            end
`endif
         end else begin
            m_active = 1'b0;
         end
      end
      if (bus.fifo_w_inc) begin
         wr_cyc.push_back(cyc);
         wr_val.push_back(bus.fifo_wr_data);
      end
      if (bus.ack0) begin ack_cyc.push_back(cyc); ack_idx.push_back(0); end
      if (bus.ack1) begin ack_cyc.push_back(cyc); ack_idx.push_back(1); end
`ifdef FIFO_ARB_TIMEOUT_EN
      if (bus.drop) drop_cyc.push_back(cyc);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mark();
      wb = wr_val.size();
      ab = ack_cyc.size();
      db = drop_cyc.size();
      t0 = cyc;
   endtask

   task automatic start(input int k, input logic [2*DW-1:0] d, input logic l);
      if (k == 0) begin
         bus.data0 = d; bus.len0 = l; bus.req0 = 1'b1;
      end else begin
         bus.data1 = d; bus.len1 = l; bus.req1 = 1'b1;
      end
   endtask

   // Requester side: drop REQ in the ACK cycle so it is low by the edge ending it.
   task automatic wait_ack(input int k, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if ((k == 0) ? bus.ack0 : bus.ack1) begin
            seen = 1'b1;
            if (k == 0) bus.req0 = 1'b0;
            else        bus.req1 = 1'b0;
         end
      end
      chk($sformatf("ack_wait_req%0d", k), seen, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.data0 = '0;  bus.data1 = '0;
      bus.len0 = 1'b0; bus.len1 = 1'b0;
      bus.fifo_full = 1'b0;
      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
      join_none

      #1;
      chk("reset_busy", bus.busy, 0);
      chk("reset_winc", bus.fifo_w_inc, 0);
      repeat (3) step();
      rst = 1'b0;
      step();

      // Two-word frame on an empty FIFO
      mark();
      start(0, 16'hA55A, 1'b1);
      wait_ack(0, 20);
      step(); step();
      chk("s1_nwr", wr_val.size() - wb, 2);
      chk("s1_lo", wv(0), 8'h5A);
      chk("s1_lo_cyc", wc(0), t0 + 1);
      chk("s1_hi", wv(1), 8'hA5);
      chk("s1_hi_cyc", wc(1), t0 + 2);
      chk("s1_ack_cyc", ac(0), t0 + 3);
      chk("s1_ack_idx", ai(0), 0);

      // Single-word frame
      mark();
      start(1, 16'h1234, 1'b0);
      wait_ack(1, 20);
      step(); step();
      chk("s2_nwr", wr_val.size() - wb, 1);
      chk("s2_lo", wv(0), 8'h34);
      chk("s2_lo_cyc", wc(0), t0 + 1);
      chk("s2_ack_cyc", ac(0), t0 + 2);
      chk("s2_ack_idx", ai(0), 1);

      // Tie after reset, then requester 0 re-requests while 1 still waits
      rst = 1'b1; step(); rst = 1'b0; step();
      mark();
      start(0, 16'hB2C1, 1'b1);
      start(1, 16'hD4E3, 1'b0);
      fork
         begin
            wait_ack(0, 20);
            step();
            start(0, 16'h5F6E, 1'b0);
            wait_ack(0, 30);
         end
         wait_ack(1, 30);
      join
      step(); step();
      chk("s3_ack_idx0", ai(0), 0);
      chk("s3_ack_idx1", ai(1), 1);
      chk("s3_ack_idx2", ai(2), 0);
      chk("s3_w0", wv(0), 8'hC1);
      chk("s3_w1", wv(1), 8'hB2);
      chk("s3_w2", wv(2), 8'hE3);
      chk("s3_w2_cyc", wc(2), t0 + 5);
      chk("s3_w3", wv(3), 8'h6E);
      chk("s3_ack_cyc2", ac(2), t0 + 9);

      // FULL for 5 cycles during WR_HI
      mark();
      start(0, 16'h7E81, 1'b1);
      fork
         wait_ack(0, 40);
         begin
            step(); step();
            bus.fifo_full = 1'b1;
            repeat (5) step();
            bus.fifo_full = 1'b0;
         end
      join
      step(); step();
      chk("s4_nwr", wr_val.size() - wb, 2);
      chk("s4_lo_cyc", wc(0), t0 + 1);
      chk("s4_hi", wv(1), 8'h7E);
      chk("s4_hi_cyc", wc(1), t0 + 7);
      chk("s4_ack_cyc", ac(0), t0 + 8);

      // Reset while in WR_HI after the low word went out
      mark();
      start(0, 16'hC33C, 1'b1);
      step(); step();
      rst = 1'b1;
      #1;
      chk("s5_busy", bus.busy, 0);
      chk("s5_winc", bus.fifo_w_inc, 0);
      chk("s5_wdat", bus.fifo_wr_data, 0);
      chk("s5_ack0", bus.ack0, 0);
      chk("s5_nwr", wr_val.size() - wb, 1);
      bus.req0 = 1'b0;
      step();
      rst = 1'b0;
      step();
      mark();
      start(0, 16'h0102, 1'b0);
      start(1, 16'h0304, 1'b0);
      fork
         wait_ack(0, 20);
         wait_ack(1, 20);
      join
      step(); step();
      chk("s5_tie_idx0", ai(0), 0);
      chk("s5_tie_w0", wv(0), 8'h02);
      chk("s5_tie_idx1", ai(1), 1);
      chk("s5_tie_w1_cyc", wc(1), t0 + 4);

`ifdef FIFO_ARB_TIMEOUT_EN
      // FULL stuck high in WR_LO: frame aborted with nothing written
      mark();
      bus.fifo_full = 1'b1;
      start(0, 16'hEEFF, 1'b1);
      wait_ack(0, 20);
      step(); step();
      bus.fifo_full = 1'b0;
      chk("s6_nwr", wr_val.size() - wb, 0);
      chk("s6_ndrop", drop_cyc.size() - db, 1);
      chk("s6_drop_cyc", (db < drop_cyc.size()) ? drop_cyc[db] : -1, t0 + 5);
      chk("s6_ack_cyc", ac(0), t0 + 5);
      step();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
